dlx_fetch_stage: RTL

- Instruction-fetch stage of the DLX pipeline, directly upstream of the instruction ROM.
- Holds the program counter and drives the word address into the combinational ROM.
- Captures the returned instruction, with its PC and next-PC, into the IF/ID pipeline register for decode.
- Supports decode-stage stall, flush and branch redirect; stops fetching past the end of the program.

---
 rtl/dlx_pkg.sv | 16 +
 rtl/dlx_ifid_reg.sv | 40 ++++
 rtl/dlx_fetch_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: NOP encoding, opcode width, fetch FSM state encoding
// and the default fetch geometry.
package dlx_pkg;

  localparam int          ADDR_W_DEF     = 32;
  localparam int          PROG_WORDS_DEF = 64;
  localparam logic [31:0] NOP_INSTR      = 32'h0;
  localparam int          OPCODE_W       = 6;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/dlx_ifid_reg.sv
// IF/ID pipeline register: squash clears instr/valid, load captures a fetched
// instruction, hold freezes everything. squash wins over load.
module dlx_ifid_reg
  import dlx_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load,
  input  logic              squash,
  input  logic              hold,
  input  logic [31:0]       instr_d,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [ADDR_W-1:0] npc_d,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] npc_o,
  output logic              valid_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instr_o <= NOP_INSTR;
      pc_o    <= '0;
      npc_o   <= '0;
      valid_o <= 1'b0;
    end else if (squash) begin
      // pc_o/npc_o keep their last values; only the instruction is killed
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (load && !hold) begin
      instr_o <= instr_d;
      pc_o    <= pc_d;
      npc_o   <= npc_d;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch stage: PC, BOOT/RUN/DONE FSM and IF/ID register.
// Define DLX_FETCH_PERF_EN to add saturating fetch/stall performance counters.
module dlx_fetch_stage
  import dlx_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PROG_WORDS = PROG_WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] npc_o,
  output logic              valid_o,
  output logic              done_o,
`ifdef DLX_FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o,
`endif
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W-1:0] PROG_END = ADDR_W'(PROG_WORDS);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              done_q;
  logic              in_fetch;
  logic              advance;
  logic              ifid_squash;

  // Handshake: stall_i is a level "decode not ready"; a capture happens only
  // on a RUN cycle with stall_i=0 and no branch/flush. Branch and flush act
  // regardless of stall_i.
  always_comb begin
    pc_inc      = pc + ADDR_W'(1);
    in_fetch    = (state == RUN) || (state == DONE);
    advance     = (state == RUN) && !branch_taken_i && !flush_i && !stall_i;
    ifid_squash = in_fetch &&
                  (branch_taken_i || flush_i || ((state == DONE) && !stall_i));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= BOOT;
      pc     <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= RUN;
          done_q <= 1'b0;
        end
        RUN, DONE: begin
          if (branch_taken_i) begin
            pc <= branch_target_i;
            if (branch_target_i >= PROG_END) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              done_q <= 1'b0;
            end
          end else if (advance) begin
            pc <= pc_inc;
            if (pc_inc == PROG_END) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= BOOT;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o = pc;
  assign done_o     = done_q;
  assign state_o    = state;

  dlx_ifid_reg #(.ADDR_W(ADDR_W)) u_ifid (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load    (advance),
    .squash  (ifid_squash),
    .hold    (stall_i),
    .instr_d (rom_data_i),
    .pc_d    (pc),
    .npc_d   (pc_inc),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .npc_o   (npc_o),
    .valid_o (valid_o)
  );

`ifdef DLX_FETCH_PERF_EN
  logic stall_event;
  assign stall_event = (state == RUN) && stall_i && !branch_taken_i && !flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (advance && (perf_fetch_cnt_o != 32'hFFFF_FFFF))
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (stall_event && (perf_stall_cnt_o != 32'hFFFF_FFFF))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
